// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable modulo, prescaled step rate,
// synchronous clear/load and wrap-or-saturate boundary handling.
module counter_updown_mod #(
  parameter int N        = 8,
  parameter int MAX      = 2**N-1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         ovf,
  output logic         at_max,
  output logic         at_min
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [N-1:0]  MAX_V    = N'(MAX);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [N-1:0]  cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tc_q, tc_d;
  logic          ovf_q, ovf_d;
  logic          step;
  logic          bound;

  assign step  = en && (pre_q == PRE_LAST);
  assign bound = dir ? (cnt_q == '0) : (cnt_q == MAX_V);

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      pre_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
      pre_d = '0;
    end else if (en) begin
      pre_d = step ? '0 : pre_q + PW'(1);
      if (step) begin
        if (bound) begin
          // Boundary step: flag it, then wrap or hold at the edge
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SATURATE == 0)
            cnt_d = dir ? MAX_V : '0;
        end else begin
          cnt_d = dir ? cnt_q - N'(1) : cnt_q + N'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q      = cnt_q;
  assign tc     = tc_q;
  assign ovf    = ovf_q;
  assign at_max = (cnt_q == MAX_V);
  assign at_min = (cnt_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: four configurations share stimulus,
// each checked every cycle against an arithmetic reference model.
module tb_counter_updown_mod;

  localparam int NI = 4;
  localparam int PN[NI]   = '{4, 4, 4, 5};
  localparam int PMAX[NI] = '{9, 9, 15, 20};
  localparam int PPS[NI]  = '{1, 1, 3, 2};
  localparam int PSAT[NI] = '{0, 1, 0, 1};

  logic       clk;
  logic       reset;
  logic       en, dir, clear, load;
  logic [4:0] lv;
  logic [3:0] q0, q1, q2;
  logic [4:0] q3;
  logic [3:0] tcv, ovfv, amx, amn;

  int checks = 0;
  int errors = 0;

  int mq[NI];
  int mpre[NI];
  bit mtc[NI];
  bit movf[NI];

  counter_updown_mod #(.N(4), .MAX(9), .PRESCALE(1), .SATURATE(0)) u0 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear),
    .load(load), .load_val(lv[3:0]), .q(q0), .tc(tcv[0]),
    .ovf(ovfv[0]), .at_max(amx[0]), .at_min(amn[0]));
  counter_updown_mod #(.N(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) u1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear),
    .load(load), .load_val(lv[3:0]), .q(q1), .tc(tcv[1]),
    .ovf(ovfv[1]), .at_max(amx[1]), .at_min(amn[1]));
  counter_updown_mod #(.N(4), .MAX(15), .PRESCALE(3), .SATURATE(0)) u2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear),
    .load(load), .load_val(lv[3:0]), .q(q2), .tc(tcv[2]),
    .ovf(ovfv[2]), .at_max(amx[2]), .at_min(amn[2]));
  counter_updown_mod #(.N(5), .MAX(20), .PRESCALE(2), .SATURATE(1)) u3 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear),
    .load(load), .load_val(lv), .q(q3), .tc(tcv[3]),
    .ovf(ovfv[3]), .at_max(amx[3]), .at_min(amn[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_q(int i);
    case (i)
      0: return 32'(q0);
      1: return 32'(q1);
      2: return 32'(q2);
      default: return 32'(q3);
    endcase
  endfunction

  // Reference: modular arithmetic on integers, one step per PRESCALE
  // enabled edges.
  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        mq[i] = 0; mpre[i] = 0; mtc[i] = 0; movf[i] = 0;
      end else begin
        int v;
        bit edge_hit;
        mtc[i] = 0;
        v = int'(lv) % (1 << PN[i]);
        if (clear) begin
          mq[i] = 0; mpre[i] = 0; movf[i] = 0;
        end else if (load) begin
          mq[i] = (v > PMAX[i]) ? PMAX[i] : v;
          mpre[i] = 0;
        end else if (en) begin
          mpre[i] = (mpre[i] + 1) % PPS[i];
          if (mpre[i] == 0) begin
            edge_hit = dir ? (mq[i] == 0) : (mq[i] == PMAX[i]);
            if (edge_hit) begin
              mtc[i] = 1; movf[i] = 1;
            end
            if (!(edge_hit && PSAT[i] != 0))
              mq[i] = (mq[i] + (dir ? PMAX[i] : 1)) % (PMAX[i] + 1);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("q[%0d]", i), dut_q(i), mq[i]);
      chk($sformatf("tc[%0d]", i), 32'(tcv[i]), 32'(mtc[i]));
      chk($sformatf("ovf[%0d]", i), 32'(ovfv[i]), 32'(movf[i]));
      chk($sformatf("at_max[%0d]", i), 32'(amx[i]),
          32'(mq[i] == PMAX[i]));
      chk($sformatf("at_min[%0d]", i), 32'(amn[i]), 32'(mq[i] == 0));
    end
  end

  task automatic step(bit e, bit d, bit c, bit l, logic [4:0] v);
    en = e; dir = d; clear = c; load = l; lv = v;
    @(posedge clk);
    #1;
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn[4]  = '{1, 0, 9, 8};
  int exp_ps[9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    reset = 1'b1;
    en = 0; dir = 0; clear = 0; load = 0; lv = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset q0", 32'(q0), 0);
    chk("reset tc0", 32'(tcv[0]), 0);
    chk("reset ovf0", 32'(ovfv[0]), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 0);
      chk("up q0", 32'(q0), exp_up[i]);
      chk("up tc0", 32'(tcv[0]), 32'(i == 9));
      chk("up ovf0", 32'(ovfv[0]), 32'(i >= 9));
    end

    step(0, 0, 0, 1, 5'd2);
    chk("load q0", 32'(q0), 2);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0);
      chk("down q0", 32'(q0), exp_dn[i]);
      chk("down tc0", 32'(tcv[0]), 32'(i == 2));
    end
    step(0, 0, 0, 1, 5'd13);
    chk("clamp q0", 32'(q0), 9);
    chk("clamp q2", 32'(q2), 13);
    chk("clamp q3", 32'(q3), 13);

    step(0, 0, 0, 1, 5'd8);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("sat q1", 32'(q1), 9);
      chk("sat tc1", 32'(tcv[1]), 32'(i != 0));
    end
    step(0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("sat low q1", 32'(q1), 0);
    chk("sat low tc1", 32'(tcv[1]), 1);

    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 0, 0);
      chk("pre q2", 32'(q2), exp_ps[i]);
    end
    step(1, 0, 0, 0, 0);
    chk("pre run q2", 32'(q2), 3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pre freeze q2", 32'(q2), 3);
    step(1, 0, 0, 0, 0);
    chk("pre resume q2", 32'(q2), 3);
    step(1, 0, 0, 0, 0);
    chk("pre step q2", 32'(q2), 4);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("dir mid q2", 32'(q2), 4);
    step(1, 1, 0, 0, 0);
    chk("dir step q2", 32'(q2), 3);

    step(0, 0, 0, 1, 5'd9);
    step(1, 0, 0, 0, 0);
    chk("wrap ovf0", 32'(ovfv[0]), 1);
    step(0, 0, 1, 1, 5'd5);
    chk("prio q0", 32'(q0), 0);
    chk("prio ovf0", 32'(ovfv[0]), 0);
    step(0, 0, 0, 1, 5'd9);
    step(1, 0, 0, 1, 5'd5);
    chk("load over step q0", 32'(q0), 5);
    chk("load over step tc0", 32'(tcv[0]), 0);

    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 5'd15);
    repeat (3) step(1, 0, 0, 0, 0);
    chk("pre wrap q2", 32'(q2), 0);
    chk("pre wrap ovf2", 32'(ovfv[2]), 1);
    step(0, 0, 0, 1, 5'd7);
    repeat (2) step(1, 0, 0, 0, 0);
    chk("pre arm q2", 32'(q2), 7);
    #2 reset = 1'b1;
    #1;
    chk("async q2", 32'(q2), 0);
    chk("async ovf2", 32'(ovfv[2]), 0);
    chk("async tc2", 32'(tcv[2]), 0);
    reset = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("post rst q2", 32'(q2), 0);
    step(1, 0, 0, 0, 0);
    chk("post rst step q2", 32'(q2), 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
           $urandom_range(31, 0) == 0, $urandom_range(7, 0) == 0,
           5'($urandom_range(31, 0)));
      if ($urandom_range(99, 0) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
